clk_div_multi: RTL and testbench

- Runtime-programmable, multi-channel clock divider.
- Generates NCH independent square-wave enables from CLK_in. Each channel's half-period is programmable through a write port, and reprogramming is glitch-free.
- Serves display multiplexing, debounce sampling and slow-tick generation, replacing fixed compile-time dividers.
- Also provides a global restart (sync) that phase-aligns all channels.

---
 rtl/clk_div_multi.sv | 130 +++++++++++++
 tb/tb_clk_div_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Runtime-programmable multi-channel clock divider: glitch-free half-period reload and global sync.
// Define CLK_DIV_TICK_EN to add a registered one-cycle tick_out pulse per CLK_out transition.
module clk_div_multi #(
   parameter int unsigned      NCH          = 4,
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(99999),
   localparam int unsigned     CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK_in,
   input  logic             RST_in,
   input  logic             en_in,
   input  logic             sync_in,
   input  logic             wr_en,
   input  logic [CHW-1:0]   wr_ch,
   input  logic [WIDTH-1:0] wr_half,
   output logic [NCH-1:0]   CLK_out,
   output logic [NCH-1:0]   pending_out
`ifdef CLK_DIV_TICK_EN
   ,
   output logic [NCH-1:0]   tick_out
`endif
);

   typedef struct packed {
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] active;
      logic [WIDTH-1:0] shadow;
      logic             pending;
      logic             out;
   } chan_t;

   chan_t          ch_q [NCH];
   chan_t          ch_d [NCH];
   logic [NCH-1:0] edge_evt;

   // Per-channel next state; priority is sync, then write-to-stopped, then terminal count, then count.
   always_comb begin
      logic hit;
      logic run;
      logic tc;
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      hit      = 1'b0;
      run      = 1'b0;
      tc       = 1'b0;
      edge_evt = '0;
      for (int c = 0; c < NCH; c++) begin
         ch_d[c] = ch_q[c];
         hit     = wr_en && (wr_ch == CHW'(c));
         run     = (ch_q[c].active != '0);
         tc      = run && (ch_q[c].cnt == ch_q[c].active - WIDTH'(1));

         if (sync_in) begin
            ch_d[c].cnt = '0;
            ch_d[c].out = 1'b0;
            if (hit) begin
               ch_d[c].active  = wr_half;
               ch_d[c].shadow  = wr_half;
               ch_d[c].pending = 1'b0;
            end else if (ch_q[c].pending) begin
               ch_d[c].active  = ch_q[c].shadow;
               ch_d[c].pending = 1'b0;
            end
         end else if (hit && !run) begin
            ch_d[c].active = wr_half;
            ch_d[c].shadow = wr_half;
            ch_d[c].cnt    = '0;
            ch_d[c].out    = 1'b0;
         end else begin
            if (hit) begin
               ch_d[c].shadow  = wr_half;
               ch_d[c].pending = 1'b1;
            end
            if (en_in && tc) begin
               ch_d[c].cnt = '0;
               edge_evt[c] = 1'b1;
               // A write landing on this terminal count waits for the next one.
               if (ch_q[c].pending && !hit) begin
                  ch_d[c].active  = ch_q[c].shadow;
                  ch_d[c].pending = 1'b0;
                  ch_d[c].out     = (ch_q[c].shadow == '0) ? 1'b0 : ~ch_q[c].out;
               end else begin
                  ch_d[c].out = ~ch_q[c].out;
               end
            end else if (en_in && run) begin
               ch_d[c].cnt = ch_q[c].cnt + WIDTH'(1);
            end
         end
      end
   end

   // NOTE: the per-channel arrays are control state rather than bulk storage, so every entry is reset.
   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         for (int c = 0; c < NCH; c++) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            ch_q[c] <= '{cnt: '0, active: DEFAULT_HALF, shadow: DEFAULT_HALF, pending: 1'b0, out: 1'b0};
         end
      end else begin
         ch_q <= ch_d;
      end
   end

   always_comb begin
      CLK_out     = '0;
      pending_out = '0;
      for (int c = 0; c < NCH; c++) begin
         CLK_out[c]     = ch_q[c].out;
         pending_out[c] = ch_q[c].pending;
      end
   end

`ifdef CLK_DIV_TICK_EN
   logic [NCH-1:0] tick_q;

   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         tick_q <= '0;
      end else begin
         tick_q <= edge_evt;
      end
   end

   assign tick_out = tick_q;
`else
   // Without ticks the edge strobe has no consumer and is optimised away.
   logic unused_edge;
   assign unused_edge = ^edge_evt;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed steps plus random traffic against an edge-countdown model.
// Tick checks are compiled in when CLK_DIV_TICK_EN is defined.
module tb_clk_div_multi;
   localparam int NCH   = 3;
   localparam int WIDTH = 16;
   localparam int DEF   = 3;
   localparam int CHW   = 2;

   logic             CLK_in = 1'b0;
   logic             RST_in;
   logic             en_in;
   logic             sync_in;
   logic             wr_en;
   logic [CHW-1:0]   wr_ch;
   logic [WIDTH-1:0] wr_half;
   logic [NCH-1:0]   CLK_out;
   logic [NCH-1:0]   pending_out;
`ifdef CLK_DIV_TICK_EN
   logic [NCH-1:0]   tick_out;
`endif

   int checks   = 0;
   int failures = 0;

   // Model: half period, cycles left to the next edge, output level, queued half (-1 = none), tick.
   int m_half [NCH];
   int m_rem  [NCH];
   int m_lvl  [NCH];
   int m_nxt  [NCH];
   int m_tick [NCH];

   always #5 CLK_in = ~CLK_in;

   clk_div_multi #(
      .NCH          (NCH),
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (16'(DEF))
   ) dut (
      .CLK_in      (CLK_in),
      .RST_in      (RST_in),
      .en_in       (en_in),
      .sync_in     (sync_in),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_half     (wr_half),
      .CLK_out     (CLK_out),
      .pending_out (pending_out)
`ifdef CLK_DIV_TICK_EN
      ,
      .tick_out    (tick_out)
`endif
   );

   task automatic check_vec(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, got, want);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit s, input bit w, input int wch, input int wh);
      for (int c = 0; c < NCH; c++) begin
         bit hit;
         hit       = w && (wch == c);
         m_tick[c] = 0;
         if (r) begin
            m_half[c] = DEF;
            m_rem[c]  = DEF;
            m_lvl[c]  = 0;
            m_nxt[c]  = -1;
         end else if (s) begin
            m_lvl[c] = 0;
            if (hit) begin
               m_half[c] = wh;
               m_nxt[c]  = -1;
            end else if (m_nxt[c] >= 0) begin
               m_half[c] = m_nxt[c];
               m_nxt[c]  = -1;
            end
            m_rem[c] = m_half[c];
         end else if (hit && m_half[c] == 0) begin
            m_half[c] = wh;
            m_rem[c]  = wh;
            m_lvl[c]  = 0;
         end else begin
            if (e && m_half[c] > 0) begin
               m_rem[c]--;
               if (m_rem[c] == 0) begin
                  m_tick[c] = 1;
                  if (m_nxt[c] >= 0 && !hit) begin
                     m_half[c] = m_nxt[c];
                     m_nxt[c]  = -1;
                  end
                  m_lvl[c] = (m_half[c] == 0) ? 0 : 1 - m_lvl[c];
                  m_rem[c] = m_half[c];
               end
            end
            if (hit) m_nxt[c] = wh;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare just after it.
   task automatic step(input bit r, input bit e, input bit s, input bit w, input int wch, input int wh);
      logic [NCH-1:0] exp_clk;
      logic [NCH-1:0] exp_pend;
      logic [NCH-1:0] exp_tick;
      RST_in  = r;
      en_in   = e;
      sync_in = s;
      wr_en   = w;
      wr_ch   = CHW'(wch);
      wr_half = WIDTH'(wh);
      @(posedge CLK_in);
      model_step(r, e, s, w, wch, wh);
      #1;
      for (int c = 0; c < NCH; c++) begin
         exp_clk[c]  = (m_lvl[c] != 0);
         exp_pend[c] = (m_nxt[c] >= 0);
         exp_tick[c] = (m_tick[c] != 0);
      end
      check_vec("model_clk_out", CLK_out, exp_clk);
      check_vec("model_pending_out", pending_out, exp_pend);
`ifdef CLK_DIV_TICK_EN
      check_vec("model_tick_out", tick_out, exp_tick);
`endif
   endtask

   initial begin
      int n;
`ifdef CLK_DIV_TICK_EN
      int ticks;
      int edges;
      logic [NCH-1:0] prev;
`endif
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check_vec("reset_clk", CLK_out, '0);
      check_vec("reset_pending", pending_out, '0);

      // Reprogram ch1 while running at cnt=0; applied at its cycle-3 terminal count.
      step(0, 1, 0, 1, 1, 2);
      check_vec("write_pending", pending_out, 3'b010);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check_vec("first_rise", CLK_out, 3'b111);
      check_vec("write_applied", pending_out, 3'b000);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check_vec("ch1_period4", CLK_out, 3'b101);

      // Stop ch0, then restart it from the stopped state.
      step(0, 1, 0, 1, 0, 0);
      for (n = 0; n < 20 && pending_out[0]; n++) step(0, 1, 0, 0, 0, 0);
      check_int("stop_pending_clear", int'(pending_out[0]), 0);
      check_int("stop_level", int'(CLK_out[0]), 0);
      step(0, 1, 0, 1, 0, 5);
      for (n = 1; n <= 20; n++) begin
         step(0, 1, 0, 0, 0, 0);
         if (CLK_out[0]) break;
      end
      check_int("restart_rise_delay", n, 5);

      // Sync with ch1 pending: pending value goes live immediately.
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 7);
      check_int("sync_pre_pending", int'(pending_out[1]), 1);
      step(0, 1, 1, 0, 0, 0);
      check_vec("sync_clk", CLK_out, '0);
      check_vec("sync_pending", pending_out, '0);
      for (n = 1; n <= 30; n++) begin
         step(0, 1, 0, 0, 0, 0);
         if (CLK_out[1]) break;
      end
      check_int("sync_ch1_rise", n, 7);

      // Freeze ch1 three cycles into its high phase; four cycles remain after resume.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
      check_int("freeze_level", int'(CLK_out[1]), 1);
      for (n = 1; n <= 30; n++) begin
         step(0, 1, 0, 0, 0, 0);
         if (!CLK_out[1]) break;
      end
      check_int("resume_remaining", n, 4);

      // Out-of-range channel write leaves every channel untouched.
      step(0, 1, 0, 1, 3, 1);
      check_vec("bad_ch_pending", pending_out, '0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
      end

      // Reset mid-period after writes: defaults return on every channel.
      step(0, 1, 0, 1, 2, 4);
      step(0, 1, 0, 1, 0, 6);
      step(1, 1, 0, 0, 0, 0);
      check_vec("rst_clk", CLK_out, '0);
      check_vec("rst_pending", pending_out, '0);
      for (n = 1; n <= 20; n++) begin
         step(0, 1, 0, 0, 0, 0);
         if (CLK_out[2]) break;
      end
      check_int("rst_default_rise", n, DEF);

`ifdef CLK_DIV_TICK_EN
      ticks = 0;
      edges = 0;
      prev  = CLK_out;
      for (int i = 0; i < 1000; i++) begin
         step(0, 1, 0, 0, 0, 0);
         edges += $countones(CLK_out ^ prev);
         ticks += $countones(tick_out);
         prev   = CLK_out;
      end
      check_int("tick_vs_edges", ticks, edges);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
